// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings and lane helpers for the dmem_ctrl data-memory access controller.
// Used by dmem_ctrl (top) and dmem_load_align.
package dmem_ctrl_pkg;

    localparam logic [1:0] SIZE_B   = 2'd0;
    localparam logic [1:0] SIZE_H   = 2'd1;
    localparam logic [1:0] SIZE_W   = 2'd2;
    localparam logic [1:0] SIZE_ILL = 2'd3;

    typedef enum logic {
        OWN_CORE   = 1'b0,
        OWN_LOADER = 1'b1
    } owner_e;

    typedef struct packed {
        owner_e     owner;
        logic       we;
        logic [1:0] size;
        logic [1:0] offset;
        logic       uns;
        logic       err;
    } resp_info_t;

    // Misaligned halves and words are truncated to their natural boundary.
    function automatic logic [1:0] lane_offset(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SIZE_H:  return {addr_lo[1], 1'b0};
            SIZE_W:  return 2'b00;
            default: return addr_lo;
        endcase
    endfunction

    function automatic logic [3:0] lane_we(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 4'b0001 << offset;
            SIZE_H:  return 4'b0011 << offset;
            SIZE_W:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replication puts the store byte/half into every lane it could target.
    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            SIZE_B:  return {4{wdata[7:0]}};
            SIZE_H:  return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-data alignment: shifts the addressed bytes of the bank word down and
// sign- or zero-extends them to 32 bits. Purely combinational.
module dmem_load_align
    import dmem_ctrl_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] rdata
);

    logic [31:0] shifted;
    logic        sign_b;
    logic        sign_h;

    assign shifted = mem_rdata >> {offset, 3'b000};
    assign sign_b  = ~is_unsigned & shifted[7];
    assign sign_h  = ~is_unsigned & shifted[15];

    always_comb begin
        rdata = '0;
        case (size)
            SIZE_B:  rdata = {{24{sign_b}}, shifted[7:0]};
            SIZE_H:  rdata = {{16{sign_h}}, shifted[15:0]};
            SIZE_W:  rdata = shifted;
            default: rdata = '0;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Two-port (core / loader) access controller for four byte-lane data-memory banks.
// Optional DMEM_CTRL_MISALIGN_CHECK_EN turns misaligned half/word accesses into errors.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int CORE_PRIORITY = 0,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              c_req,
    output logic              c_ready,
    input  logic              c_we,
    input  logic [ADDR_W-1:0] c_addr,
    input  logic [31:0]       c_wdata,
    input  logic [1:0]        c_size,
    input  logic              c_unsigned,
    output logic              c_rvalid,
    output logic [31:0]       c_rdata,
    output logic              c_err,

    input  logic              l_req,
    output logic              l_ready,
    input  logic              l_we,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [31:0]       l_wdata,
    input  logic [1:0]        l_size,
    input  logic              l_unsigned,
    output logic              l_rvalid,
    output logic [31:0]       l_rdata,
    output logic              l_err,

    output logic              mem_valid,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    owner_e            last_grant;
    logic              grant_c;
    logic              grant_l;
    logic              grant_any;

    owner_e            sel_owner;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [31:0]       sel_wdata;
    logic [1:0]        sel_size;
    logic              sel_uns;
    logic [1:0]        sel_off;
    logic              sel_err;

    resp_info_t        resp_q;
    logic              resp_valid_q;
    logic [31:0]       load_data;
    logic [31:0]       resp_rdata;

    always_comb begin
        grant_c = 1'b0;
        grant_l = 1'b0;
        if (c_req && l_req) begin
            if (CORE_PRIORITY != 0 || last_grant == OWN_LOADER) begin
                grant_c = 1'b1;
            end else begin
                grant_l = 1'b1;
            end
        end else begin
            grant_c = c_req;
            grant_l = l_req;
        end
    end

    assign grant_any = grant_c | grant_l;
    assign c_ready   = grant_c;
    assign l_ready   = grant_l;

    always_comb begin
        sel_owner = OWN_CORE;
        sel_we    = c_we;
        sel_addr  = c_addr;
        sel_wdata = c_wdata;
        sel_size  = c_size;
        sel_uns   = c_unsigned;
        if (grant_l) begin
            sel_owner = OWN_LOADER;
            sel_we    = l_we;
            sel_addr  = l_addr;
            sel_wdata = l_wdata;
            sel_size  = l_size;
            sel_uns   = l_unsigned;
        end
    end

    assign sel_off = lane_offset(sel_size, sel_addr[1:0]);

`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
    assign sel_err = (sel_size == SIZE_ILL)
                   || (sel_size == SIZE_H && sel_addr[0])
                   || (sel_size == SIZE_W && sel_addr[1:0] != 2'b00);
`else
    assign sel_err = (sel_size == SIZE_ILL);
`endif

    // Erroring requests are still accepted but never reach the banks.
    always_comb begin
        mem_valid = 1'b0;
        mem_we    = 4'b0000;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_any && !sel_err) begin
            mem_valid = 1'b1;
            mem_addr  = {sel_addr[ADDR_W-1:2], 2'b00};
            if (sel_we) begin
                mem_we    = lane_we(sel_size, sel_off);
                mem_wdata = lane_wdata(sel_size, sel_wdata);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q <= 1'b0;
            resp_q       <= '0;
            last_grant   <= OWN_LOADER;
        end else begin
            resp_valid_q <= grant_any;
            if (grant_any) begin
                resp_q.owner  <= sel_owner;
                resp_q.we     <= sel_we;
                resp_q.size   <= sel_size;
                resp_q.offset <= sel_off;
                resp_q.uns    <= sel_uns;
                resp_q.err    <= sel_err;
                last_grant    <= sel_owner;
            end
        end
    end

    dmem_load_align u_load_align (
        .mem_rdata   (mem_rdata),
        .offset      (resp_q.offset),
        .size        (resp_q.size),
        .is_unsigned (resp_q.uns),
        .rdata       (load_data)
    );

    assign resp_rdata = (resp_q.we || resp_q.err) ? 32'h0 : load_data;

    assign c_rvalid = resp_valid_q && (resp_q.owner == OWN_CORE);
    assign l_rvalid = resp_valid_q && (resp_q.owner == OWN_LOADER);
    assign c_err    = c_rvalid && resp_q.err;
    assign l_err    = l_rvalid && resp_q.err;
    assign c_rdata  = c_rvalid ? resp_rdata : 32'h0;
    assign l_rdata  = l_rvalid ? resp_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed scoreboard bench for dmem_ctrl: round-robin instance with a bank model,
// plus a fixed-priority instance used for arbitration and reset-state checks.
module tb_dmem_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        c_req, c_we, c_unsigned;
    logic [31:0] c_addr, c_wdata;
    logic [1:0]  c_size;
    logic        l_req, l_we, l_unsigned;
    logic [31:0] l_addr, l_wdata;
    logic [1:0]  l_size;

    logic        c_ready, c_rvalid, c_err, l_ready, l_rvalid, l_err;
    logic [31:0] c_rdata, l_rdata;
    logic        mem_valid;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    logic        p1_c_ready, p1_c_rvalid, p1_c_err, p1_l_ready, p1_l_rvalid, p1_l_err;
    logic [31:0] p1_c_rdata, p1_l_rdata;
    logic        p1_mem_valid;
    logic [3:0]  p1_mem_we;
    logic [31:0] p1_mem_addr, p1_mem_wdata, p1_mem_rdata;

    assign p1_mem_rdata = 32'h0;

    dmem_ctrl #(.CORE_PRIORITY(0), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_ready(c_ready), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_size(c_size), .c_unsigned(c_unsigned), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .c_err(c_err),
        .l_req(l_req), .l_ready(l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_size(l_size), .l_unsigned(l_unsigned), .l_rvalid(l_rvalid), .l_rdata(l_rdata), .l_err(l_err),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    dmem_ctrl #(.CORE_PRIORITY(1), .ADDR_W(32)) dut_p1 (
        .clk(clk), .rst_n(rst_n),
        .c_req(c_req), .c_ready(p1_c_ready), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_size(c_size), .c_unsigned(c_unsigned), .c_rvalid(p1_c_rvalid), .c_rdata(p1_c_rdata), .c_err(p1_c_err),
        .l_req(l_req), .l_ready(p1_l_ready), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_size(l_size), .l_unsigned(l_unsigned), .l_rvalid(p1_l_rvalid), .l_rdata(p1_l_rdata), .l_err(p1_l_err),
        .mem_valid(p1_mem_valid), .mem_we(p1_mem_we), .mem_addr(p1_mem_addr), .mem_wdata(p1_mem_wdata),
        .mem_rdata(p1_mem_rdata)
    );

    // Four byte-lane banks with registered read, 64 words deep.
    logic [31:0] bank [0:63];
    always @(posedge clk) begin
        if (mem_valid) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_we[i]) bank[mem_addr[7:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
            mem_rdata <= bank[mem_addr[7:2]];
        end
    end

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_due;
    int          checks;
    int          errors;
    logic [31:0] c_exp_rd, l_exp_rd;
    logic        c_exp_err, l_exp_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_c(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] exp_rd, input logic exp_err);
        c_req = req; c_we = we; c_addr = addr; c_wdata = wdata; c_size = size; c_unsigned = uns;
        c_exp_rd = exp_rd; c_exp_err = exp_err;
    endtask

    task automatic set_l(input logic req, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] exp_rd, input logic exp_err);
        l_req = req; l_we = we; l_addr = addr; l_wdata = wdata; l_size = size; l_unsigned = uns;
        l_exp_rd = exp_rd; l_exp_err = exp_err;
    endtask

    // Mid-cycle: check responses owed from the previous cycle, then record this cycle's grants.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (!rst_n) begin
            sb.delete();
            n_due = 0;
        end
        if (n_due > 0) begin
            e = sb.pop_front();
            sb.delete();
            n_due = 0;
            chk("rvalid_c", 32'(c_rvalid), 32'(e.port == 1'b0));
            chk("rvalid_l", 32'(l_rvalid), 32'(e.port == 1'b1));
            chk("rdata", e.port ? l_rdata : c_rdata, e.rdata);
            chk("err", 32'(e.port ? l_err : c_err), 32'(e.err));
        end else begin
            chk("idle_rvalid", 32'({c_rvalid, l_rvalid}), 32'h0);
        end
        chk("one_grant", 32'(c_ready & l_ready), 32'h0);
        if (rst_n) begin
            if (c_ready) begin
                e = '{port: 1'b0, rdata: c_exp_rd, err: c_exp_err};
                sb.push_back(e);
                n_due++;
            end
            if (l_ready) begin
                e = '{port: 1'b1, rdata: l_exp_rd, err: l_exp_err};
                sb.push_back(e);
                n_due++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] exp_c;
        checks = 0;
        errors = 0;
        n_due  = 0;
        rst_n  = 1'b0;
        set_c(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        set_l(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;

        sample();
        chk("rst_c_out", {31'h0, c_err} | c_rdata, 32'h0);
        chk("rst_l_out", {31'h0, l_err} | l_rdata, 32'h0);
        chk("rst_mem_valid", 32'({mem_valid, p1_mem_valid}), 32'h0);
        chk("rst_p1_resp", 32'({p1_c_rvalid, p1_l_rvalid, p1_c_err, p1_l_err}), 32'h0);
        chk("rst_p1_rdata", p1_c_rdata | p1_l_rdata, 32'h0);
        chk("rst_p1_mem", p1_mem_addr | p1_mem_wdata | 32'(p1_mem_we), 32'h0);
        advance();
        rst_n = 1'b1;

        set_c(1, 1, 32'h10, 32'hDEADBEEF, 2'd2, 0, 32'h0, 0);
        sample();
        chk("sw_valid", 32'(mem_valid), 32'h1);
        chk("sw_we", 32'(mem_we), 32'hF);
        chk("sw_addr", mem_addr, 32'h10);
        chk("sw_wdata", mem_wdata, 32'hDEADBEEF);
        advance();

        set_c(1, 0, 32'h10, 32'h0, 2'd2, 0, 32'hDEADBEEF, 0);
        sample();
        chk("lw_valid", 32'(mem_valid), 32'h1);
        chk("lw_we", 32'(mem_we), 32'h0);
        advance();

        set_c(1, 1, 32'h13, 32'h12345680, 2'd0, 0, 32'h0, 0);
        sample();
        chk("sb_we", 32'(mem_we), 32'h8);
        chk("sb_wdata", mem_wdata, 32'h80808080);
        chk("sb_addr", mem_addr, 32'h10);
        advance();

        set_c(1, 0, 32'h13, 32'h0, 2'd0, 0, 32'hFFFFFF80, 0);
        sample();
        advance();
        set_c(1, 0, 32'h13, 32'h0, 2'd0, 1, 32'h00000080, 0);
        sample();
        advance();

        set_c(1, 1, 32'h20, 32'hAABBCCDD, 2'd2, 0, 32'h0, 0);
        sample();
        advance();
        set_c(1, 1, 32'h22, 32'hFFFF1234, 2'd1, 0, 32'h0, 0);
        sample();
        chk("sh_we", 32'(mem_we), 32'hC);
        chk("sh_wdata_hi", 32'(mem_wdata[31:16]), 32'h1234);
        advance();
        set_c(1, 0, 32'h20, 32'h0, 2'd2, 0, 32'h1234CCDD, 0);
        sample();
        advance();

        set_c(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        set_l(1, 0, 32'h20, 32'h0, 2'd1, 0, 32'hFFFFCCDD, 0);
        sample();
        chk("ld_ready", 32'({c_ready, l_ready}), 32'h1);
        advance();

        set_l(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
`ifdef DMEM_CTRL_MISALIGN_CHECK_EN
        set_c(1, 0, 32'h21, 32'h0, 2'd2, 0, 32'h0, 1);
        sample();
        chk("mis_valid", 32'(mem_valid), 32'h0);
`else
        set_c(1, 0, 32'h21, 32'h0, 2'd2, 0, 32'h1234CCDD, 0);
        sample();
        chk("mis_valid", 32'(mem_valid), 32'h1);
        chk("mis_addr", mem_addr, 32'h20);
`endif
        advance();

        set_c(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        set_l(1, 0, 32'h24, 32'h0, 2'd3, 0, 32'h0, 1);
        sample();
        chk("ill_ready", 32'(l_ready), 32'h1);
        chk("ill_valid", 32'(mem_valid), 32'h0);
        advance();

        set_c(1, 1, 32'h30, 32'h11111111, 2'd2, 0, 32'h0, 0);
        set_l(1, 1, 32'h34, 32'h22222222, 2'd2, 0, 32'h0, 0);
        for (int i = 0; i < 6; i++) begin
            sample();
            exp_c = (i % 2 == 0) ? 32'h1 : 32'h0;
            chk("rr_c_ready", 32'(c_ready), exp_c);
            chk("rr_l_ready", 32'(l_ready), exp_c ^ 32'h1);
            chk("prio_c_ready", 32'({p1_c_ready, p1_l_ready}), 32'h2);
            advance();
        end

        set_l(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        set_c(1, 0, 32'h10, 32'h0, 2'd2, 0, 32'h80ADBEEF, 0);
        sample();
        advance();
        rst_n = 1'b0;
        set_c(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        sample();
        chk("rst_drop", 32'(c_rvalid), 32'h0);
        advance();
        sample();
        advance();
        rst_n = 1'b1;

        set_c(1, 0, 32'h10, 32'h0, 2'd2, 0, 32'h80ADBEEF, 0);
        set_l(1, 0, 32'h20, 32'h0, 2'd2, 0, 32'h1234CCDD, 0);
        sample();
        chk("post_rst_c", 32'({c_ready, l_ready}), 32'h2);
        advance();
        set_c(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        sample();
        chk("post_rst_l", 32'(l_ready), 32'h1);
        advance();
        set_l(0, 0, 32'h0, 32'h0, 2'd0, 0, 32'h0, 0);
        sample();
        advance();
        sample();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
